// File: rtl/jk_down_counter.sv
// -----------------------------------------------------------------------------
// jk_down_counter
//
// Loadable down-counter built from per-bit JK flip-flop cells. Used as a
// programmable timer / event divider: load a start value, decrement once per
// enabled cycle, then either wrap to all-ones or halt at zero. A registered,
// one-cycle terminal-count pulse (tc) marks every 1->0 step caused by a
// decrement.
//
// This file holds two modules:
//   jk_ff            single positive-edge JK cell with asynchronous clear
//   jk_down_counter  top level: controller FSM, JK steering, tc pipeline
//
// jk_down_counter ports:
//   clk         in   rising-edge clock, the only clock
//   reset_n     in   asynchronous active-low reset
//   load        in   synchronous load of load_value (wins over enable)
//   load_value  in   [WIDTH-1:0] start value captured on load
//   enable      in   count enable, one decrement per cycle while high
//   wrap        in   1 = wrap 0 -> all-ones, 0 = halt at 0 (sampled each cycle)
//   count       out  [WIDTH-1:0] current value (JK cell Q outputs)
//   zero        out  combinational, high when count == 0
//   tc          out  registered terminal-count pulse, one cycle wide
//   halted      out  high while the controller is in HALT
//   dbg_state   out  [1:0] raw controller state (0 IDLE, 1 COUNT, 2 HALT)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// jk_ff: one JK flip-flop cell.
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low clear
//   i_j, i_k   J/K inputs (11 toggle, 10 set, 01 clear, 00 hold)
//   o_q        cell output
// -----------------------------------------------------------------------------
module jk_ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// -----------------------------------------------------------------------------
// jk_down_counter: top level.
// -----------------------------------------------------------------------------
module jk_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             wrap,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             halted,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  // Controller and tc pipeline registers
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_tc_pend;   // a decrement just produced 1 -> 0
  logic       r_tc;        // pulse output, one cycle behind r_tc_pend

  // Datapath wires
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_borrow;     // bits below i are all zero
  logic             w_zero;
  logic             w_one;
  logic             w_load_halt;  // a load that lands directly in HALT
  logic             w_stall_zero; // at zero, asked to count, not wrapping
  logic             w_dec;        // a decrement is applied this cycle

  // ---------------------------------------------------------------------------
  // Count value decode
  // ---------------------------------------------------------------------------
  assign w_zero = (w_count == '0);
  assign w_one  = (w_count == WIDTH'(1));

  // ---------------------------------------------------------------------------
  // Control qualifiers. Priority inside a cycle is load, then enable; enable
  // only matters in COUNT. At zero without wrap the controller parks in HALT
  // instead of decrementing, so the count never leaves 0 in that case.
  // ---------------------------------------------------------------------------
  assign w_load_halt  = (load_value == '0) && !wrap;
  assign w_stall_zero = !load && (r_state == S_COUNT) && enable &&
                        w_zero && !wrap;
  assign w_dec        = !load && (r_state == S_COUNT) && enable &&
                        !(w_zero && !wrap);

  // ---------------------------------------------------------------------------
  // Borrow chain: bit i toggles on a decrement when every lower bit is 0.
  // Bit 0 has no lower bits, so it always toggles. From all-zeros every bit
  // toggles, which is exactly the wrap to all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_borrow    = '0;
    w_borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_borrow[i] = w_borrow[i-1] & ~w_count[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // JK steering. Load forces each cell with J=value, K=~value (set or clear);
  // a decrement drives J=K=borrow (toggle or hold); otherwise all cells hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_j = '0;
    w_k = '0;
    if (load) begin
      w_j = load_value;
      w_k = ~load_value;
    end else if (w_dec) begin
      w_j = w_borrow;
      w_k = w_borrow;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_ff u_cell (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_j       (w_j[gi]),
      .i_k       (w_k[gi]),
      .o_q       (w_count[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Controller FSM. Load retargets from any state; a zero load without wrap
  // goes straight to HALT so no tc can ever come from a load.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = w_load_halt ? S_HALT : S_COUNT;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_COUNT: w_state_nxt = w_stall_zero ? S_HALT : S_COUNT;
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Terminal count. The 1 -> 0 decrement is captured at the edge that makes
  // it, then registered once more so tc is high for the cycle following the
  // first cycle at zero. Only a decrement from 1 arms it, so wrapping from 0
  // and loading 0 never produce a pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tc_pend <= 1'b0;
      r_tc      <= 1'b0;
    end else begin
      r_tc_pend <= w_dec && w_one;
      r_tc      <= r_tc_pend;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count     = w_count;
  assign zero      = w_zero;
  assign tc        = r_tc;
  assign halted    = (r_state == S_HALT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_jk_down_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_down_counter: self-checking bench for jk_down_counter (WIDTH=4).
// A behavioural reference model is stepped alongside every driven cycle; its
// expected {state, count, zero, tc, halted} is pushed to exp_q and popped and
// compared just after the clock edge that should produce it.
// -----------------------------------------------------------------------------
module tb_jk_down_counter;

  localparam int W  = 4;
  localparam int PW = W + 5;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_COUNT = 2'd1;
  localparam logic [1:0] M_HALT  = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         wrap;
  logic [W-1:0] count;
  logic         zero;
  logic         tc;
  logic         halted;
  logic [1:0]   dbg_state;

  jk_down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .wrap       (wrap),
    .count      (count),
    .zero       (zero),
    .tc         (tc),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];

  logic [1:0]   m_state;
  logic [W-1:0] m_count;
  logic         m_pend;
  logic         m_tc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (state,count,zero,tc,halted)",
               tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_count = '0;
    m_pend  = 1'b0;
    m_tc    = 1'b0;
  endfunction

  function automatic void model_step(input logic l, input logic [W-1:0] lv,
                                     input logic e, input logic w);
    logic new_pend;
    new_pend = 1'b0;
    if (l) begin
      m_count = lv;
      m_state = (lv == 0 && !w) ? M_HALT : M_COUNT;
    end else if (m_state == M_COUNT && e) begin
      if (m_count == 0) begin
        if (w) m_count = '1;
        else   m_state = M_HALT;
      end else begin
        if (m_count == 1) new_pend = 1'b1;
        m_count = m_count - 1'b1;
      end
    end
    m_tc   = m_pend;
    m_pend = new_pend;
  endfunction

  function automatic logic [PW-1:0] model_pack();
    return {m_state, m_count, (m_count == 0), m_tc, (m_state == M_HALT)};
  endfunction

  function automatic logic [PW-1:0] dut_pack();
    return {dbg_state, count, zero, tc, halted};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input logic l, input logic [W-1:0] lv, input logic e,
                      input logic w, input string tag);
    logic [PW-1:0] exp;
    load       = l;
    load_value = lv;
    enable     = e;
    wrap       = w;
    model_step(l, lv, e, w);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, 32'(dut_pack()), 32'(exp));
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check(tag, 32'(dut_pack()), 32'(model_pack()));
    @(negedge clk);
    load    = 1'b0;
    enable  = 1'b0;
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n    = 1'b0;
    load       = 1'b0;
    load_value = '0;
    enable     = 1'b0;
    wrap       = 1'b0;
    model_reset();
    #2;
    check("por", 32'(dut_pack()), 32'(model_pack()));
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE ignores enable
    tick(0, 4'd0, 1, 0, "idle_en");
    tick(0, 4'd0, 1, 1, "idle_en_wrap");

    // Basic countdown, halt at zero, stays halted
    tick(1, 4'd3, 0, 0, "basic_load");
    for (int i = 0; i < 9; i++) tick(0, 4'd0, 1, 0, "basic_cnt");

    // Wrap mode: 1,0,15,14,... single tc
    tick(1, 4'd1, 0, 1, "wrap_load");
    for (int i = 0; i < 5; i++) tick(0, 4'd0, 1, 1, "wrap_cnt");

    // Load beats enable on the same edge
    tick(1, 4'd7, 0, 1, "prio_load7");
    tick(0, 4'd0, 1, 1, "prio_to6");
    tick(1, 4'd9, 1, 1, "prio_load9");
    tick(0, 4'd0, 1, 1, "prio_to8");

    // Enable gaps
    tick(1, 4'd4, 0, 0, "gap_load");
    begin
      logic [6:0] pat;
      pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
      for (int i = 0; i < 7; i++) tick(0, 4'd0, pat[i], 0, "gap_cnt");
    end
    for (int i = 0; i < 3; i++) tick(0, 4'd0, 0, 0, "gap_idle");

    // Zero load goes straight to HALT, then recover with a load of 2
    tick(1, 4'd0, 0, 0, "zload");
    tick(0, 4'd0, 1, 0, "zload_hold");
    tick(0, 4'd0, 1, 0, "zload_hold");
    tick(1, 4'd2, 0, 0, "recover_load");
    for (int i = 0; i < 4; i++) tick(0, 4'd0, 1, 0, "recover_cnt");

    // Zero load with wrap set stays in COUNT and wraps without tc
    tick(1, 4'd0, 0, 1, "zload_wrap");
    tick(0, 4'd0, 1, 1, "zload_wrap_cnt");
    tick(0, 4'd0, 1, 1, "zload_wrap_cnt");

    // All-ones load, and wrap changed mid-count
    tick(1, 4'd15, 0, 0, "ones_load");
    for (int i = 0; i < 3; i++) tick(0, 4'd0, 1, 0, "ones_cnt");
    tick(1, 4'd2, 0, 1, "wchg_load");
    tick(0, 4'd0, 1, 1, "wchg_cnt");
    tick(0, 4'd0, 1, 1, "wchg_cnt");
    tick(0, 4'd0, 1, 0, "wchg_halt");
    tick(0, 4'd0, 1, 0, "wchg_halt");

    // Reset mid-count at 5
    tick(1, 4'd5, 0, 0, "rst5_load");
    async_reset("rst_mid");
    tick(0, 4'd0, 1, 0, "rst_after");

    // Reset while tc is high
    tick(1, 4'd1, 0, 0, "rsttc_load");
    tick(0, 4'd0, 1, 0, "rsttc_cnt");
    tick(0, 4'd0, 1, 0, "rsttc_tc");
    async_reset("rst_tc");
    tick(0, 4'd0, 0, 0, "rsttc_after");
    tick(0, 4'd0, 0, 0, "rsttc_after");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jk_down_counter.md
# jk_down_counter

Synchronous, loadable down-counter built from per-bit JK flip-flop cells, the count-down counterpart of the team's D-flip-flop up-counter. It serves as a programmable timer and event divider. It loads a start value, decrements once per enabled cycle, and either wraps or halts at zero. A registered terminal-count pulse is produced for downstream logic.

## Interface
- WIDTH, 4, counter width in bits (2..16)
- clk  input  1  rising-edge clock, the only clock
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  synchronous load of load_value; highest priority after reset
- load_value  input  WIDTH  start value captured on load
- enable  input  1  count enable; one decrement per cycle while high
- wrap  input  1  1 = wrap from 0 to all-ones; 0 = halt at 0
- count  output  WIDTH  current counter value (JK cell Q outputs)
- zero  output  1  combinational, high when count == 0
- tc  output  1  registered terminal-count pulse, one cycle wide
- halted  output  1  high while in HALT state

## Operation
- Each bit is a JK flip-flop cell, positive-edge triggered, with an async clear on reset_n.
  - J=K=1 toggles; J=1,K=0 sets; J=0,K=1 clears; J=K=0 holds.
- Down-count toggle rule: bit i toggles when the decrement is active and bits 0..i-1 are all 0. Bit 0 always toggles on a decrement.
- Load rule: J_i = load_value[i], K_i = ~load_value[i].
- Controller FSM states: IDLE, COUNT, HALT.
  - IDLE: count holds. load moves to COUNT, or to HALT if load_value == 0 and wrap == 0. enable without load is ignored.
  - COUNT: when enable=1, count decrements.
    - At count == 1 with a decrement, the next count is 0 and tc=1 next cycle.
    - At count == 0 with a decrement and wrap=1, the next count is all-ones and tc is not re-asserted.
    - At count == 0 with wrap=0, the FSM moves to HALT and no decrement occurs.
  - HALT: count holds at 0 and halted=1. enable is ignored. Only load leaves HALT, with the same target rules as from IDLE.
- Priority each cycle: reset_n low, then load, then enable.
  - load and enable high together: load wins, and no decrement is applied that cycle.
- tc asserts for exactly one cycle, on the cycle after a 1→0 transition caused by a decrement.
  - A load of 0 never raises tc.
- wrap is sampled every cycle. Changing wrap mid-count affects only the next zero crossing.

## Timing
- Reset (reset_n low, asynchronous, takes effect immediately, no clock needed):
  - count = 0, tc = 0, FSM = IDLE, halted = 0.
  - zero = 1, since it is combinational on count.
- Release of reset_n is synchronous to clk. The first active edge after release may load.
- Load latency: 1 cycle. count == load_value is visible after the edge where load=1.
- Decrement latency: 1 cycle per enabled edge. Period from load N (N>0) to the tc pulse with enable held high:
  - count reaches 0 at edge N after the load edge.
  - tc is high during the cycle after edge N+1, registered from the transition.
- zero is combinational from count and is valid in the same cycle as count.
- Reset mid-count: count clears immediately, tc drops immediately, and the FSM returns to IDLE. No tc is generated by reset.
- enable low in COUNT: count and state hold indefinitely, and tc is unaffected.
- WIDTH boundary: load of all-ones is legal. All-ones is reached in wrap mode only by wrapping from 0.

## Test plan
- Reset: drive reset_n low mid-cycle with count=5 → count=0, zero=1, tc=0, halted=0 before the next clk edge.
- Basic countdown (WIDTH=4, wrap=0): load 3, then enable high → count 3,2,1,0 on successive edges, tc high for one cycle after 1→0, then halted=1 and count stays 0 for 5 further enabled cycles.
- Wrap mode (wrap=1): load 1, enable → count 1,0,15,14; tc pulses once only, after 1→0; halted stays 0.
- Priority: count=6 in COUNT, load=1 with load_value=9 and enable=1 on the same edge → count=9 (not 8); next enabled edge gives 8.
- Enable gaps: load 4, enable pattern 1,0,0,1,1,0,1 → count 4,3,3,3,2,1,1,0 and a single tc after the final 1→0.
- Zero load and recovery: load 0 with wrap=0 → HALT immediately, no tc. Then load 2 → COUNT, and two enabled edges reach 0 with a tc pulse.
